switch_scheduler: RTL
=====================

# switch_scheduler

Crossbar scheduler for the 4-port packet switch. Sits between the four per-ingress packet FIFOs and the four egress ports. Fans each legal packet out to every port in its target mask (unicast, multicast or broadcast) using an independent round-robin arbiter per egress port. Pops the ingress FIFO only after every copy has been accepted, and discards illegal packets with a saturating drop count.

## Interface
- NUM_PORTS, 4, number of ingress/egress ports; only 4 is supported (one-hot nibble encoding)
- PKT_WIDTH, 16, packet width: [15:12] source one-hot, [11:8] target mask, [7:0] data
- CNT_WIDTH, 16, width of drop counter
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  NUM_PORTS  bit i: ingress FIFO i head is valid
- in_pkt  in  NUM_PORTS*PKT_WIDTH  head of FIFO i at [i*PKT_WIDTH +: PKT_WIDTH]; first-word-fall-through, advances on the edge that samples in_pop[i]
- in_pop  out  NUM_PORTS  one-cycle pop strobe to FIFO i
- out_valid  out  NUM_PORTS  egress o holds a packet
- out_pkt  out  NUM_PORTS*PKT_WIDTH  packet for egress o, unmodified copy of ingress packet
- out_ready  in  NUM_PORTS  egress o accepts; transfer when out_valid[o] & out_ready[o]
- drop_cnt  out  CNT_WIDTH  count of illegal packets discarded, saturating

## Operation
- Legality per ingress head, source S, target T:
  - Illegal if T==0.
  - Illegal if S==0 or S not one-hot.
  - Illegal if T!=4'b1111 and (S&T)!=0.
- Delivery mask: T==4'b1111 gives 4'b1111 & ~S (broadcast never returns to source); otherwise T.
- Per-ingress FSM, states IDLE, ACTIVE, POP; holds pending[i] (NUM_PORTS bits).
  - IDLE & in_valid[i] & illegal -> POP; drop_cnt += 1 unless at all-ones.
  - IDLE & in_valid[i] & legal -> ACTIVE; pending[i] = delivery mask; packet latched in pkt_reg[i].
  - ACTIVE: bit o of pending[i] clears on the edge where egress o completes a transfer sourced from i. When next-state pending is zero -> POP.
  - POP: in_pop[i]=1 for exactly this cycle -> IDLE.
- Per-egress arbiter, with rr_ptr[o] (2 bits) and gnt_src[o]:
  - Requesters: inputs in ACTIVE with next-state pending[i][o]=1 and not currently held by egress o.
  - A new grant is made when out_valid[o]==0 or a transfer completes this cycle.
  - Search order is rr_ptr[o], rr_ptr[o]+1, … mod 4. The first requester wins.
  - On grant: out_valid[o]=1, out_pkt[o]=pkt_reg[winner], gnt_src[o]=winner, rr_ptr[o]=winner+1 mod 4.
  - On transfer with no requester: out_valid[o]=0.
- One input may be held by several egress ports at once (multicast copies in parallel).
- out_pkt[o] and out_valid[o] stay stable while out_valid[o]&~out_ready[o].

## Timing
- Reset values: in_pop=0, out_valid=0, out_pkt=0, drop_cnt=0, all FSMs IDLE, pending=0, rr_ptr=0.
- Reset mid-operation clears all in-flight state immediately. FIFO contents are not popped; the head is re-evaluated after reset.
- Legal packet latency:
  - Head valid in cycle 0 (IDLE); ACTIVE in cycle 1.
  - out_valid rises in cycle 2.
  - If accepted in cycle 2 on all target ports, in_pop=1 in cycle 3; next head is evaluated in cycle 4.
- Illegal packet: head in cycle 0, in_pop=1 in cycle 1; nothing appears on any egress.
- Back-to-back: an egress completing a transfer can present the next granted packet in the following cycle with no bubble.
- Simultaneous completion on several egress ports for the same input clears all those bits in one edge.
- drop_cnt holds at 2^CNT_WIDTH-1.

## Test plan
- Unicast: port0 head 16'h1_2_A5 (S=0001, T=0010), out_ready=1111 -> out_valid[1] in cycle 2 with out_pkt[1]=16'h12A5; in_pop[0] in cycle 3; no other egress asserts.
- Broadcast: port2 head 16'h4_F_3C -> copies on egress 0, 1, 3 simultaneously in cycle 2; egress 2 silent; single in_pop[2].
- Contention: ports 0, 1, 3 all target 0100 (S legal), out_ready[2]=1 -> egress 2 serves inputs 0, 1, 3 in consecutive cycles. With input 0 reloaded, the next grant goes to 0 only after 3 (round-robin).
- Backpressure: multicast T=0110 from port0, out_ready[1]=1, out_ready[2]=0 for 5 cycles -> egress 1 done at cycle 2, egress 2 holds a stable out_pkt; in_pop[0] is delayed until the cycle after out_ready[2] rises.
- Illegal: heads 16'h1_1_00 (self-loop), 16'h0_2_00 (no source), 16'h3_4_00 (multi-source), 16'h1_0_00 (no target) -> each popped one cycle after presentation, drop_cnt=4, zero egress traffic.
- Reset: assert rst_n=0 while an egress is stalled mid-multicast -> all outputs zero asynchronously; after release the same head is redelivered to all targets.

Source files
------------

// File: rtl/switch_scheduler.sv
// Crossbar scheduler for a 4-port packet switch: per-ingress fan-out FSMs feeding
// per-egress round-robin arbiters, with illegal-packet discard and a saturating drop count.
//
// state     | meaning
// ST_IDLE   | waiting for a valid FIFO head; judges legality
// ST_ACTIVE | packet latched; waiting for every egress copy in pending[i] to be accepted
// ST_POP    | pop strobe to the ingress FIFO for one cycle
module switch_scheduler #(
   parameter int NUM_PORTS = 4,
   parameter int PKT_WIDTH = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_PORTS-1:0]           in_valid,
   input  logic [NUM_PORTS*PKT_WIDTH-1:0] in_pkt,
   output logic [NUM_PORTS-1:0]           in_pop,
   output logic [NUM_PORTS-1:0]           out_valid,
   output logic [NUM_PORTS*PKT_WIDTH-1:0] out_pkt,
   input  logic [NUM_PORTS-1:0]           out_ready,
   output logic [CNT_WIDTH-1:0]           drop_cnt
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam int DW = $clog2(NUM_PORTS + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_POP    = 2'd2;

   logic [1:0]           st       [NUM_PORTS];
   logic [NUM_PORTS-1:0] pending  [NUM_PORTS];
   logic [PKT_WIDTH-1:0] pkt_reg  [NUM_PORTS];
   logic [PW-1:0]        gnt_src  [NUM_PORTS];
   logic [PW-1:0]        rr_ptr   [NUM_PORTS];
   logic [PKT_WIDTH-1:0] opkt     [NUM_PORTS];

   logic [PKT_WIDTH-1:0] head     [NUM_PORTS];
   logic [NUM_PORTS-1:0] src      [NUM_PORTS];
   logic [NUM_PORTS-1:0] tgt      [NUM_PORTS];
   logic [NUM_PORTS-1:0] dmask    [NUM_PORTS];
   logic [NUM_PORTS-1:0] legal;
   logic [NUM_PORTS-1:0] drop_ev;
   logic [DW-1:0]        n_drop;

   logic [NUM_PORTS-1:0] xfer;
   logic [NUM_PORTS-1:0] done_v   [NUM_PORTS];
   logic [NUM_PORTS-1:0] held     [NUM_PORTS];
   logic [NUM_PORTS-1:0] pend_nxt [NUM_PORTS];
   logic [NUM_PORTS-1:0] req      [NUM_PORTS];
   logic [PW-1:0]        win      [NUM_PORTS];
   logic [NUM_PORTS-1:0] found;

   assign xfer = out_valid & out_ready;

   always_comb begin
      n_drop = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         head[i]  = in_pkt[i*PKT_WIDTH +: PKT_WIDTH];
         src[i]   = head[i][PKT_WIDTH-1 -: NUM_PORTS];
         tgt[i]   = head[i][PKT_WIDTH-NUM_PORTS-1 -: NUM_PORTS];
         legal[i] = (tgt[i] != '0) && (src[i] != '0) &&
                    ((src[i] & (src[i] - NUM_PORTS'(1))) == '0) &&
                    ((tgt[i] == '1) || ((src[i] & tgt[i]) == '0));
         // broadcast never loops back to its own source
         dmask[i]   = (tgt[i] == '1) ? ~src[i] : tgt[i];
         drop_ev[i] = (st[i] == ST_IDLE) && in_valid[i] && !legal[i];
         n_drop     = n_drop + DW'(drop_ev[i]);
         in_pop[i]  = (st[i] == ST_POP);
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            held[i][o]   = out_valid[o] && (gnt_src[o] == PW'(i));
            done_v[i][o] = xfer[o] && (gnt_src[o] == PW'(i));
         end
         pend_nxt[i] = pending[i] & ~done_v[i];
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            req[o][i] = (st[i] == ST_ACTIVE) && pend_nxt[i][o] && !held[i][o];
         end
      end
   end

   always_comb begin
      logic [PW-1:0] idx;
      idx = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         found[o] = 1'b0;
         win[o]   = '0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            idx = rr_ptr[o] + PW'(k);
            if (!found[o] && req[o][idx]) begin
               found[o] = 1'b1;
               win[o]   = idx;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            st[i]      <= ST_IDLE;
            pending[i] <= '0;
            pkt_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            case (st[i])
               ST_IDLE: begin
                  if (in_valid[i]) begin
                     if (legal[i]) begin
                        st[i]      <= ST_ACTIVE;
                        pending[i] <= dmask[i];
                        pkt_reg[i] <= head[i];
                     end else begin
                        st[i] <= ST_POP;
                     end
                  end
               end
               ST_ACTIVE: begin
                  pending[i] <= pend_nxt[i];
                  if (pend_nxt[i] == '0) st[i] <= ST_POP;
               end
               ST_POP:  st[i] <= ST_IDLE;
               default: st[i] <= ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (n_drop != '0) begin
         logic [CNT_WIDTH:0] sum;
         sum = {1'b0, drop_cnt} + (CNT_WIDTH+1)'(n_drop);
         drop_cnt <= sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
      end
   end

   // a new grant may replace the current packet only once it has been accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= '0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            opkt[o]    <= '0;
            gnt_src[o] <= '0;
            rr_ptr[o]  <= '0;
         end
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (!out_valid[o] || xfer[o]) begin
               if (found[o]) begin
                  out_valid[o] <= 1'b1;
                  opkt[o]      <= pkt_reg[win[o]];
                  gnt_src[o]   <= win[o];
                  rr_ptr[o]    <= win[o] + PW'(1);
               end else begin
                  out_valid[o] <= 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      out_pkt = '0;
      for (int o = 0; o < NUM_PORTS; o++) out_pkt[o*PKT_WIDTH +: PKT_WIDTH] = opkt[o];
   end

endmodule
